// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: micro-state encodings, controlword field indices and fetch defaults.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CW_W   = 31;
    localparam int unsigned K_W    = 64;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH = 2'b00,
        ST_EX0   = 2'b01,
        ST_EX1   = 2'b10,
        ST_EX2   = 2'b11
    } state_e;

    // Controlword bit positions shared with the per-format decoders
    localparam int unsigned CW_PSEL_HI = 30;
    localparam int unsigned CW_PSEL_LO = 29;
    localparam int unsigned CW_REGW    = 8;
    localparam int unsigned CW_ENMEM   = 6;
    localparam int unsigned CW_ENPC    = 3;

    // Psel=01 (PC+4), EN_MEM=1, EN_PC=1
    localparam logic [CW_W-1:0]   FETCH_CW  = 31'h2000_0048;
    localparam logic [DATA_W-1:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/ctrl_state_reg.sv
// Micro-state and halt flag register; holds unless advanced or sent to halt.
module ctrl_state_reg
    import cpu_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   adv_en,
    input  state_e nxt_state,
    input  logic   halt_req,
    output state_e state,
    output logic   halted
);

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halt_req) begin
            halted_d = 1'b1;
            state_d  = ST_FETCH;
        end else if (adv_en) begin
            state_d = nxt_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Control-unit front end: owns IR and micro-state, issues fetch controlword, forwards decoder output.
module ctrl_sequencer
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic [CW_W-1:0]   dec_controlword,
    input  logic [ST_W-1:0]   dec_nextState,
    input  logic [K_W-1:0]    dec_K,
    output logic [DATA_W-1:0] instruction,
    output logic [ST_W-1:0]   state,
    output logic [CW_W-1:0]   controlword,
    output logic [K_W-1:0]    K,
    output logic              halted,
    output logic [DATA_W-1:0] retired
);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] retired_q, retired_d;
    state_e            cur_state;
    state_e            nxt_state;
    state_e            dec_ns;
    logic              cur_halted;
    logic              adv_en;
    logic              halt_req;
    logic [CW_W-1:0]   cw_c;
    logic [K_W-1:0]    k_c;

    assign dec_ns = state_e'(dec_nextState);

    ctrl_state_reg u_state_reg (
        .clock     (clock),
        .reset     (reset),
        .adv_en    (adv_en),
        .nxt_state (nxt_state),
        .halt_req  (halt_req),
        .state     (cur_state),
        .halted    (cur_halted)
    );

    // Next-state, IR/retire update and controlword mux
    always_comb begin
        ir_d      = ir_q;
        retired_d = retired_q;
        adv_en    = 1'b0;
        halt_req  = 1'b0;
        nxt_state = cur_state;
        cw_c      = '0;
        k_c       = '0;
        if (cur_halted) begin
            cw_c = '0;
        end else if (cur_state == ST_FETCH) begin
            cw_c = FETCH_CW;
            if (mem_ready) begin
                ir_d      = mem_data;
                adv_en    = 1'b1;
                nxt_state = ST_EX0;
            end else begin
                cw_c[CW_ENPC]               = 1'b0;
                cw_c[CW_PSEL_HI:CW_PSEL_LO] = 2'b00;
            end
        end else if (cur_state == ST_EX0 && ir_q == HALT_WORD) begin
            // Halt word is caught before any decoder output reaches the datapath
            halt_req = 1'b1;
        end else begin
            cw_c = dec_controlword;
            k_c  = dec_K;
            if (dec_controlword[CW_ENMEM] && !mem_ready) begin
                // ramW stays up so a pending store can complete
                cw_c[CW_REGW] = 1'b0;
                cw_c[CW_ENPC] = 1'b0;
            end else begin
                adv_en    = 1'b1;
                nxt_state = dec_ns;
                if (dec_ns == ST_FETCH) begin
                    retired_d = retired_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign instruction = ir_q;
    assign state       = ST_W'(cur_state);
    assign controlword = cw_c;
    assign K           = k_c;
    assign halted      = cur_halted;
    assign retired     = retired_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed scoreboard bench for ctrl_sequencer.
module tb_ctrl_sequencer;

    localparam logic [30:0] FETCH_CW   = 31'h2000_0048;
    localparam logic [30:0] FETCH_WAIT = 31'h0000_0040;
    localparam logic [31:0] LDUR_W     = 32'hF840_0041;
    localparam logic [31:0] W2         = 32'h8B02_0020;
    localparam logic [31:0] W3         = 32'hF800_0062;
    localparam logic [31:0] W4         = 32'h9100_0483;
    localparam logic [30:0] CW_T1      = 31'h1A2B_3C5D;
    localparam logic [30:0] CW3        = 31'h1234_51C8;
    localparam logic [30:0] CW3_STALL  = 31'h1234_50C0;
    localparam logic [30:0] CW4        = 31'h0000_0A20;
    localparam logic [63:0] K_T1       = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] K_T4       = 64'h0000_0000_0000_0010;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [30:0] dec_controlword;
    logic [1:0]  dec_nextState;
    logic [63:0] dec_K;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [30:0] controlword;
    logic [63:0] K;
    logic        halted;
    logic [31:0] retired;

    ctrl_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .dec_controlword (dec_controlword),
        .dec_nextState   (dec_nextState),
        .dec_K           (dec_K),
        .instruction     (instruction),
        .state           (state),
        .controlword     (controlword),
        .K               (K),
        .halted          (halted),
        .retired         (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_dec(input logic [30:0] cw, input logic [1:0] ns, input logic [63:0] k);
        dec_controlword = cw;
        dec_nextState   = ns;
        dec_K           = k;
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_data = '0;
        set_dec('0, 2'b00, '0);
        tick();
        // mem_ready during reset must be ignored
        mem_ready = 1'b1;
        mem_data  = LDUR_W;
        tick();
        push("rst_state", 64'(2'b00));   pop_check(64'(state));
        push("rst_ir", 64'(32'h0));      pop_check(64'(instruction));
        push("rst_halted", 64'(1'b0));   pop_check(64'(halted));
        push("rst_retired", 64'(32'h0)); pop_check(64'(retired));

        // 1: minimum two-cycle instruction
        reset = 1'b0;
        set_dec(CW_T1, 2'b00, K_T1);
        settle();
        push("t1_fetch_cw", 64'(FETCH_CW)); pop_check(64'(controlword));
        push("t1_fetch_k", 64'h0);          pop_check(K);
        tick();
        push("t1_ex0_state", 64'(2'b01));   pop_check(64'(state));
        push("t1_ir", 64'(LDUR_W));         pop_check(64'(instruction));
        push("t1_ex0_cw", 64'(CW_T1));      pop_check(64'(controlword));
        push("t1_ex0_k", K_T1);             pop_check(K);
        tick();
        push("t1_done_state", 64'(2'b00));  pop_check(64'(state));
        push("t1_retired", 64'(32'd1));     pop_check(64'(retired));

        // 2: fetch waits on memory
        mem_ready = 1'b0;
        mem_data  = W2;
        settle();
        for (int i = 0; i < 3; i++) begin
            push("t2_wait_state", 64'(2'b00)); pop_check(64'(state));
            push("t2_wait_cw", 64'(FETCH_WAIT)); pop_check(64'(controlword));
            push("t2_wait_ir", 64'(LDUR_W));   pop_check(64'(instruction));
            tick();
        end
        mem_ready = 1'b1;
        set_dec(CW4, 2'b00, K_T4);
        settle();
        push("t2_ready_cw", 64'(FETCH_CW)); pop_check(64'(controlword));
        tick();
        push("t2_ir", 64'(W2));             pop_check(64'(instruction));
        push("t2_state", 64'(2'b01));       pop_check(64'(state));
        tick();
        push("t2_retired", 64'(32'd2));     pop_check(64'(retired));

        // 3: access stall in EX0
        mem_data = W3;
        set_dec(CW3, 2'b00, K_T1);
        tick();
        mem_ready = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            push("t3_stall_state", 64'(2'b01)); pop_check(64'(state));
            push("t3_stall_cw", 64'(CW3_STALL)); pop_check(64'(controlword));
            push("t3_stall_ir", 64'(W3));       pop_check(64'(instruction));
            tick();
        end
        mem_ready = 1'b1;
        settle();
        push("t3_release_cw", 64'(CW3));    pop_check(64'(controlword));
        push("t3_release_state", 64'(2'b01)); pop_check(64'(state));
        tick();
        push("t3_next_state", 64'(2'b00));  pop_check(64'(state));
        push("t3_retired", 64'(32'd3));     pop_check(64'(retired));

        // 4: multi-cycle decoder with a self-loop in EX1
        mem_data = W4;
        set_dec(CW4, 2'b10, K_T4);
        tick();
        push("t4_ex0", 64'(2'b01));         pop_check(64'(state));
        tick();
        push("t4_ex1", 64'(2'b10));         pop_check(64'(state));
        push("t4_ex1_retired", 64'(32'd3)); pop_check(64'(retired));
        tick();
        push("t4_loop", 64'(2'b10));        pop_check(64'(state));
        push("t4_loop_retired", 64'(32'd3)); pop_check(64'(retired));
        dec_nextState = 2'b00;
        tick();
        push("t4_done", 64'(2'b00));        pop_check(64'(state));
        push("t4_retired", 64'(32'd4));     pop_check(64'(retired));

        // 5: halt word
        mem_data = 32'h0;
        set_dec(CW_T1, 2'b00, K_T1);
        tick();
        push("t5_ex0", 64'(2'b01));         pop_check(64'(state));
        mem_data = W2;
        tick();
        for (int i = 0; i < 3; i++) begin
            push("t5_halted", 64'(1'b1));   pop_check(64'(halted));
            push("t5_state", 64'(2'b00));   pop_check(64'(state));
            push("t5_cw", 64'h0);           pop_check(64'(controlword));
            push("t5_k", 64'h0);            pop_check(K);
            push("t5_ir", 64'(32'h0));      pop_check(64'(instruction));
            push("t5_retired", 64'(32'd4)); pop_check(64'(retired));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        push("t5_unhalt", 64'(1'b0));       pop_check(64'(halted));

        // 6: reset in EX1, then retire-counter wrap
        mem_data = W4;
        set_dec(CW4, 2'b00, K_T4);
        tick();
        tick();
        push("t6_pre_retired", 64'(32'd1)); pop_check(64'(retired));
        dec_nextState = 2'b10;
        tick();
        tick();
        push("t6_in_ex1", 64'(2'b10));      pop_check(64'(state));
        reset = 1'b1;
        tick();
        push("t6_rst_state", 64'(2'b00));   pop_check(64'(state));
        push("t6_rst_ir", 64'(32'h0));      pop_check(64'(instruction));
        push("t6_rst_retired", 64'(32'h0)); pop_check(64'(retired));
        reset = 1'b0;
        mem_ready = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_q;
        settle();
        push("t6_preset", 64'(32'hFFFF_FFFF)); pop_check(64'(retired));
        mem_ready = 1'b1;
        mem_data  = LDUR_W;
        set_dec(CW4, 2'b00, K_T4);
        tick();
        tick();
        push("t6_wrap", 64'(32'h0));        pop_check(64'(retired));
        push("t6_wrap_state", 64'(2'b00));  pop_check(64'(state));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
